// File: rtl/pq_sequencer_if.sv
// pq_sequencer_if: stream bundle between a producer/consumer and pq_sequencer.
// Carries the insert stream (in_*), the pop stream (out_*) and the flush
// request. master = the side that offers data and consumes maxima,
// slave = the sequencer itself.
interface pq_sequencer_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         flush;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pq_sequencer.sv
// pq_sequencer: handshake front-end for an external DEPTH-entry priority queue.
// Tracks occupancy, turns insert/pop handshakes into queue strobes and
// exposes the queue's top as the current maximum. Pop wins over insert,
// flush wins over both and spends one cycle in FLUSH clearing the queue.
// Optional feature: define PQ_SEQUENCER_STATS_EN to get saturating
// insert/pop statistics counters; otherwise ins_cnt/pop_cnt read 0.
module pq_sequencer #(
  parameter  int W     = 8,
  parameter  int DEPTH = 6,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_L,
  pq_sequencer_if.slave bus,
  output logic [W-1:0]  pq_newVal,
  output logic          pq_loadIn,
  output logic          pq_shiftOut,
  output logic          pq_clear,
  input  logic [W-1:0]  pq_top,
  output logic [CW-1:0] count,
  output logic [15:0]   ins_cnt,
  output logic [15:0]   pop_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL,
    S_FLUSH
  } state_t;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          flush_now;
  logic          ins_hs;
  logic          pop_hs;

  // State and occupancy registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= S_EMPTY;
      count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next state and next occupancy; the state always mirrors the new count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    state_d = state_q;
    count_d = count_q;
    if (state_q == S_FLUSH) begin
      state_d = S_EMPTY;
    end else if (bus.flush) begin
      state_d = S_FLUSH;
      count_d = '0;
    end else begin
      if (pop_hs) begin
        count_d = count_q - CW'(1);
      end else if (ins_hs) begin
        count_d = count_q + CW'(1);
      end
      if (count_d == '0) begin
        state_d = S_EMPTY;
      end else if (count_d == FULL_CNT) begin
        state_d = S_FULL;
      end else begin
        state_d = S_PARTIAL;
      end
    end
  end

  // Handshakes and queue strobes derived from the current state.
  always_comb begin
    flush_now     = bus.flush && (state_q != S_FLUSH);
    bus.out_valid = (state_q == S_PARTIAL) || (state_q == S_FULL);
    pop_hs        = (state_q == S_PARTIAL || state_q == S_FULL)
                    && bus.out_ready && !flush_now;
    bus.in_ready  = (state_q == S_EMPTY || state_q == S_PARTIAL)
                    && !flush_now && !pop_hs;
    ins_hs        = bus.in_valid && bus.in_ready;
    bus.out_data  = pq_top;
    pq_newVal     = bus.in_data;
    pq_loadIn     = ins_hs;
    pq_shiftOut   = pop_hs;
    pq_clear      = (state_q == S_FLUSH);
  end

  assign count = count_q;

`ifdef PQ_SEQUENCER_STATS_EN
  logic [15:0] ins_cnt_q;
  logic [15:0] pop_cnt_q;

  // Saturating handshake counters; flush leaves them alone.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ins_cnt_q <= '0;
      pop_cnt_q <= '0;
    end else begin
      if (ins_hs && ins_cnt_q != 16'hFFFF) ins_cnt_q <= ins_cnt_q + 16'd1;
      if (pop_hs && pop_cnt_q != 16'hFFFF) pop_cnt_q <= pop_cnt_q + 16'd1;
    end
  end

  assign ins_cnt = ins_cnt_q;
  assign pop_cnt = pop_cnt_q;
`else
  assign ins_cnt = '0;
  assign pop_cnt = '0;
`endif

endmodule

// File: tb/tb_pq_sequencer.sv
// tb_pq_sequencer: randomized scoreboard bench for pq_sequencer.
// The bench emulates the attached priority queue from the DUT's strobes and
// keeps an independent reference (a plain multiset of accepted values plus
// a flush flag). Expected pop values are queued when the reference predicts
// a pop; the monitor dequeues them whenever the DUT actually pops.
module tb_pq_sequencer;
  localparam int W     = 8;
  localparam int DEPTH = 6;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef PQ_SEQUENCER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk;
  logic          reset_L;
  logic [W-1:0]  pq_newVal;
  logic          pq_loadIn;
  logic          pq_shiftOut;
  logic          pq_clear;
  logic [W-1:0]  pq_top;
  logic [CW-1:0] count;
  logic [15:0]   ins_cnt;
  logic [15:0]   pop_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  pq_sequencer_if #(.W(W)) bus ();

  pq_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .bus        (bus),
    .pq_newVal  (pq_newVal),
    .pq_loadIn  (pq_loadIn),
    .pq_shiftOut(pq_shiftOut),
    .pq_clear   (pq_clear),
    .pq_top     (pq_top),
    .count      (count),
    .ins_cnt    (ins_cnt),
    .pop_cnt    (pop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Attached priority queue, driven only by the DUT's strobes.
  always @(posedge clk or negedge reset_L) begin : attached_pq
    logic [W-1:0] mem[$];
    int pos;
    if (!reset_L) begin
      mem.delete();
      pq_top <= '0;
    end else begin
      if (pq_clear) begin
        mem.delete();
      end else if (pq_shiftOut) begin
        if (mem.size() > 0) void'(mem.pop_front());
      end else if (pq_loadIn && mem.size() < DEPTH) begin
        pos = mem.size();
        for (int i = 0; i < mem.size(); i++) begin
          if (pq_newVal > mem[i]) begin
            pos = i;
            break;
          end
        end
        mem.insert(pos, pq_newVal);
      end
      pq_top <= (mem.size() > 0) ? mem[0] : '0;
    end
  end

  // Reference model and monitor: predict at the falling edge, compare 1ns later.
  initial begin : monitor
    logic [W-1:0] ref_vals[$];
    bit ref_flushing;
    int ref_ins, ref_pop;
    bit e_valid, e_ready, e_ins, e_pop, flush_now;
    int max_idx;
    logic [W-1:0] got;
    ref_flushing = 1'b0;
    ref_ins = 0;
    ref_pop = 0;
    forever begin
      @(negedge clk);
      if (!reset_L) begin
        ref_vals.delete();
        ref_flushing = 1'b0;
        ref_ins = 0;
        ref_pop = 0;
      end
      max_idx = 0;
      for (int i = 1; i < ref_vals.size(); i++)
        if (ref_vals[i] > ref_vals[max_idx]) max_idx = i;
      e_valid   = !ref_flushing && ref_vals.size() > 0;
      flush_now = bus.flush && !ref_flushing && reset_L;
      e_pop     = e_valid && bus.out_ready && !flush_now;
      e_ready   = !ref_flushing && ref_vals.size() < DEPTH && !flush_now && !e_pop;
      e_ins     = bus.in_valid && e_ready;
      if (e_pop) exp_q.push_back(ref_vals[max_idx]);
      #1;
      check("out_valid", 32'(bus.out_valid), 32'(e_valid));
      check("in_ready", 32'(bus.in_ready), 32'(e_ready));
      check("count", 32'(count), 32'(ref_vals.size()));
      check("pq_clear", 32'(pq_clear), 32'(ref_flushing));
      check("pq_loadIn", 32'(pq_loadIn), 32'(e_ins));
      check("pq_shiftOut", 32'(pq_shiftOut), 32'(e_pop));
      check("pq_newVal", 32'(pq_newVal), 32'(bus.in_data));
      if (e_valid) check("out_data_max", 32'(bus.out_data), 32'(ref_vals[max_idx]));
      check("ins_cnt", 32'(ins_cnt), STATS ? 32'(ref_ins) : 32'd0);
      check("pop_cnt", 32'(pop_cnt), STATS ? 32'(ref_pop) : 32'd0);
      if (bus.out_valid && bus.out_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          check("pop_expected", 32'd0, 32'd1);
        end else begin
          got = exp_q.pop_front();
          check("pop_value", 32'(bus.out_data), 32'(got));
        end
      end
      check("pending_pops", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      if (reset_L) begin
        if (ref_flushing) begin
          ref_flushing = 1'b0;
        end else if (flush_now) begin
          ref_vals.delete();
          ref_flushing = 1'b1;
        end else if (e_pop) begin
          ref_vals.delete(max_idx);
          if (ref_pop < 65535) ref_pop++;
        end else if (e_ins) begin
          ref_vals.push_back(bus.in_data);
          if (ref_ins < 65535) ref_ins++;
        end
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    step(1'b0, '0, 1'b0, 1'b0);
    reset_L = 1'b0;
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin : stimulus
    logic [W-1:0] d;
    reset_L       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;

    // Insert 5, 9, 0 then pop three times (zero is a real value).
    step(1'b1, 8'd5, 1'b0, 1'b0);
    step(1'b1, 8'd9, 1'b0, 1'b0);
    step(1'b1, 8'd0, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle(2);

    // Fill to DEPTH, hold off a 7th insert, pop one, then insert again.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    step(1'b1, 8'd7, 1'b0, 1'b0);
    step(1'b1, 8'd7, 1'b1, 1'b0);
    step(1'b1, 8'd7, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // Simultaneous insert and pop at count 2: pop wins.
    step(1'b1, 8'd20, 1'b0, 1'b0);
    step(1'b1, 8'd30, 1'b0, 1'b0);
    step(1'b1, 8'd40, 1'b1, 1'b0);
    step(1'b1, 8'd40, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);

    // Flush at count 4 together with insert and pop requests.
    for (int i = 0; i < 4; i++) step(1'b1, W'(10 + i), 1'b0, 1'b0);
    step(1'b1, 8'd99, 1'b1, 1'b1);
    step(1'b1, 8'd98, 1'b1, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of a cycle at count 3.
    for (int i = 0; i < 3; i++) step(1'b1, W'(50 + i), 1'b0, 1'b0);
    idle(1);
    @(posedge clk);
    #3;
    reset_L = 1'b0;
    @(posedge clk);
    #1;
    reset_L = 1'b1;
    idle(1);

    // Statistics: 3 inserts, 2 pops, then a flush.
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b1, W'(i * 3), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic with biased data and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       d = '0;
        1:       d = '1;
        default: d = W'($urandom);
      endcase
      step($urandom_range(0, 99) < 60, d, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 2);
    end
    idle(3);
    @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
